// File: rtl/exc_stage_pipe_pkg.sv
// rtl/exc_stage_pipe_pkg.sv - shared ExcCode constants, code width and FSM encodings
//
// Purpose: common definitions for the exception-tracking stage register.
//   EXC_CODE_W matches the CP0 Cause[6:2] field. IDLE/PEND are the two
//   states of the kill-window FSM.
// Ports: none (package).
package exc_stage_pipe_pkg;

  localparam int EXC_CODE_W = 5;

  localparam logic [EXC_CODE_W-1:0] ExcCode_int  = 5'd0;
  localparam logic [EXC_CODE_W-1:0] ExcCode_adel = 5'd4;
  localparam logic [EXC_CODE_W-1:0] ExcCode_ades = 5'd5;
  localparam logic [EXC_CODE_W-1:0] ExcCode_ri   = 5'd10;
  localparam logic [EXC_CODE_W-1:0] ExcCode_ov   = 5'd12;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

endpackage

// File: rtl/exc_stage_pipe_if.sv
// rtl/exc_stage_pipe_if.sv - control/data bundle of the exception stage register
//
// Purpose: groups stall/flush, the incoming instruction/exception fields and
//   the registered outputs. EXC_STAGE_CNT_EN adds the ExcCnt counter output.
// Modports:
//   master - drives stall, flush, InstrValidIn, ExcValidIn, ExcCodeIn,
//            SrcReq, SrcCode; observes the registered outputs.
//   slave  - the stage register itself; the reverse directions.
interface exc_stage_pipe_if
  import exc_stage_pipe_pkg::*;
#(
  parameter int NSRC   = 2,
  parameter int CODE_W = EXC_CODE_W
);

  logic                     stall;
  logic                     flush;
  logic                     InstrValidIn;
  logic                     ExcValidIn;
  logic [CODE_W-1:0]        ExcCodeIn;
  logic [NSRC-1:0]          SrcReq;
  logic [NSRC*CODE_W-1:0]   SrcCode;
  logic                     InstrValidOut;
  logic                     ExcValidOut;
  logic [CODE_W-1:0]        ExcCodeOut;
  logic                     KillOut;
  logic                     Pend;
`ifdef EXC_STAGE_CNT_EN
  logic [15:0]              ExcCnt;

  modport master (
    output stall, flush, InstrValidIn, ExcValidIn, ExcCodeIn, SrcReq, SrcCode,
    input  InstrValidOut, ExcValidOut, ExcCodeOut, KillOut, Pend, ExcCnt
  );

  modport slave (
    input  stall, flush, InstrValidIn, ExcValidIn, ExcCodeIn, SrcReq, SrcCode,
    output InstrValidOut, ExcValidOut, ExcCodeOut, KillOut, Pend, ExcCnt
  );
`else
  modport master (
    output stall, flush, InstrValidIn, ExcValidIn, ExcCodeIn, SrcReq, SrcCode,
    input  InstrValidOut, ExcValidOut, ExcCodeOut, KillOut, Pend
  );

  modport slave (
    input  stall, flush, InstrValidIn, ExcValidIn, ExcCodeIn, SrcReq, SrcCode,
    output InstrValidOut, ExcValidOut, ExcCodeOut, KillOut, Pend
  );
`endif

endinterface

// File: rtl/exc_prio_sel.sv
// rtl/exc_prio_sel.sv - combinational lowest-index-wins exception source selector
//
// Purpose: picks the code of the lowest-numbered asserted request.
// Ports:
//   req      in  NSRC         request per source, index 0 highest priority
//   src_code in  NSRC*CODE_W  source i code at [i*CODE_W +: CODE_W]
//   hit      out 1            any request asserted
//   code     out CODE_W       selected code, 0 when no request
module exc_prio_sel #(
  parameter int NSRC   = 2,
  parameter int CODE_W = 5
) (
  input  logic [NSRC-1:0]        req,
  input  logic [NSRC*CODE_W-1:0] src_code,
  output logic                   hit,
  output logic [CODE_W-1:0]      code
);

  // Scan from the highest index down so the lowest set index is written last.
  always_comb begin
    hit  = |req;
    code = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        code = src_code[i*CODE_W +: CODE_W];
      end
    end
  end

endmodule

// File: rtl/exc_stage_pipe.sv
// rtl/exc_stage_pipe.sv - exception-tracking pipeline register between CPU stages
//
// Purpose: merges the upstream exception with NSRC local sources (upstream
//   first, then lowest local index), registers the result under
//   reset > flush > stall > load, and after an exception is registered marks
//   every younger valid instruction as killed until flush.
//   Optional macro EXC_STAGE_CNT_EN adds a saturating 16-bit ExcCnt of
//   IDLE->PEND entries (cleared by reset only, frozen by stall).
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset
//   bus    exc_stage_pipe_if.slave - stall/flush, inputs, registered outputs
module exc_stage_pipe
  import exc_stage_pipe_pkg::*;
#(
  parameter int NSRC   = 2,
  parameter int CODE_W = EXC_CODE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  exc_stage_pipe_if.slave       bus
);

  logic [0:0]        state;
  logic              instr_valid_q;
  logic              exc_valid_q;
  logic [CODE_W-1:0] exc_code_q;
  logic              kill_q;

  logic              loc_hit;
  logic [CODE_W-1:0] loc_code;
  logic              exc_hit;
  logic [CODE_W-1:0] exc_code_sel;
  logic              load;
  logic              enter_pend;

  exc_prio_sel #(
    .NSRC   (NSRC),
    .CODE_W (CODE_W)
  ) u_prio_sel (
    .req      (bus.SrcReq),
    .src_code (bus.SrcCode),
    .hit      (loc_hit),
    .code     (loc_code)
  );

  // The upstream exception was detected first for the same instruction,
  // so it beats every local source.
  assign exc_hit      = bus.ExcValidIn | loc_hit;
  assign exc_code_sel = bus.ExcValidIn ? bus.ExcCodeIn : loc_code;

  assign load       = !reset && !bus.flush && !bus.stall;
  assign enter_pend = load && bus.InstrValidIn && (state == IDLE) && exc_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      instr_valid_q <= 1'b0;
      exc_valid_q   <= 1'b0;
      exc_code_q    <= '0;
      kill_q        <= 1'b0;
    end else if (bus.flush) begin
      state         <= IDLE;
      instr_valid_q <= 1'b0;
      exc_valid_q   <= 1'b0;
      exc_code_q    <= '0;
      kill_q        <= 1'b0;
    end else if (!bus.stall) begin
      instr_valid_q <= bus.InstrValidIn;
      if (!bus.InstrValidIn) begin
        // Bubble: nothing to kill or report; state is left alone.
        exc_valid_q <= 1'b0;
        exc_code_q  <= '0;
        kill_q      <= 1'b0;
      end else if (state == PEND) begin
        // Younger than the pending exception; its own exceptions are dropped.
        exc_valid_q <= 1'b0;
        exc_code_q  <= '0;
        kill_q      <= 1'b1;
      end else if (exc_hit) begin
        exc_valid_q <= 1'b1;
        exc_code_q  <= exc_code_sel;
        kill_q      <= 1'b0;
        state       <= PEND;
      end else begin
        exc_valid_q <= 1'b0;
        exc_code_q  <= ExcCode_int[CODE_W-1:0];
        kill_q      <= 1'b0;
      end
    end
  end

  assign bus.InstrValidOut = instr_valid_q;
  assign bus.ExcValidOut   = exc_valid_q;
  assign bus.ExcCodeOut    = exc_code_q;
  assign bus.KillOut       = kill_q;
  assign bus.Pend          = (state == PEND);

`ifdef EXC_STAGE_CNT_EN
  logic [15:0] exc_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      exc_cnt_q <= '0;
    end else if (enter_pend && (exc_cnt_q != 16'hFFFF)) begin
      exc_cnt_q <= exc_cnt_q + 16'd1;
    end
  end

  assign bus.ExcCnt = exc_cnt_q;
`else
  logic unused_enter_pend;
  assign unused_enter_pend = enter_pend;
`endif

endmodule

// File: tb/tb_exc_stage_pipe.sv
// tb/tb_exc_stage_pipe.sv - self-checking bench for exc_stage_pipe
module tb_exc_stage_pipe;
  import exc_stage_pipe_pkg::*;

  localparam int NSRC   = 2;
  localparam int CODE_W = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exc_stage_pipe_if #(.NSRC(NSRC), .CODE_W(CODE_W)) bus ();

  exc_stage_pipe #(.NSRC(NSRC), .CODE_W(CODE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic              rst;
    logic              stall;
    logic              flush;
    logic              ivi;
    logic              evi;
    logic [CODE_W-1:0] cin;
    logic [NSRC-1:0]   req;
    logic [CODE_W-1:0] c1;
    logic [CODE_W-1:0] c0;
    logic              e_ivo;
    logic              e_evo;
    logic [CODE_W-1:0] e_code;
    logic              e_kill;
    logic              e_pend;
  } vec_t;

  vec_t vq[$];

  // Reference model state
  logic              m_ivo, m_evo, m_kill, m_pend;
  logic [CODE_W-1:0] m_code;
  int                m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic fl, input logic ivi,
                       input logic evi, input logic [CODE_W-1:0] cin,
                       input logic [NSRC-1:0] req, input logic [CODE_W-1:0] c1,
                       input logic [CODE_W-1:0] c0);
    reset            = rst;
    bus.stall        = st;
    bus.flush        = fl;
    bus.InstrValidIn = ivi;
    bus.ExcValidIn   = evi;
    bus.ExcCodeIn    = cin;
    bus.SrcReq       = req;
    bus.SrcCode      = {c1, c0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: one clock edge applied to the current inputs.
  task automatic model_edge();
    logic              hit;
    logic [CODE_W-1:0] code;
    if (reset) begin
      m_ivo = 0; m_evo = 0; m_code = 0; m_kill = 0; m_pend = 0; m_cnt = 0;
    end else if (bus.flush) begin
      m_ivo = 0; m_evo = 0; m_code = 0; m_kill = 0; m_pend = 0;
    end else if (!bus.stall) begin
      m_ivo = bus.InstrValidIn;
      m_evo = 0; m_code = 0; m_kill = 0;
      if (bus.InstrValidIn) begin
        if (m_pend) begin
          m_kill = 1;
        end else begin
          hit  = 0;
          code = 0;
          if (bus.ExcValidIn) begin
            hit  = 1;
            code = bus.ExcCodeIn;
          end else begin
            for (int i = 0; i < NSRC; i++) begin
              if (!hit && bus.SrcReq[i]) begin
                hit  = 1;
                code = bus.SrcCode[i*CODE_W +: CODE_W];
              end
            end
          end
          if (hit) begin
            m_evo  = 1;
            m_code = code;
            m_pend = 1;
            if (m_cnt < 65535) m_cnt++;
          end
        end
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // rst st fl ivi evi cin req c1 c0 | ivo evo code kill pend
    vq.push_back('{1,0,0,1,1,ExcCode_ri,2'b11,ExcCode_ov,ExcCode_adel, 0,0,0,0,0});
    vq.push_back('{1,1,0,1,1,5'd7,2'b01,5'd3,5'd9,                    0,0,0,0,0});
    vq.push_back('{0,0,0,1,1,ExcCode_ri,2'b11,ExcCode_ov,ExcCode_adel, 1,1,ExcCode_ri,0,1});
    vq.push_back('{0,0,1,1,0,0,2'b00,0,0,                             0,0,0,0,0});
    vq.push_back('{0,0,0,1,0,ExcCode_ri,2'b11,ExcCode_ov,ExcCode_adel, 1,1,ExcCode_adel,0,1});
    vq.push_back('{0,0,0,1,0,0,2'b10,ExcCode_ov,ExcCode_adel,         1,0,0,1,1});
    vq.push_back('{0,0,0,0,0,0,2'b10,ExcCode_ov,ExcCode_adel,         0,0,0,0,1});
    vq.push_back('{0,0,0,1,0,0,2'b10,ExcCode_ov,ExcCode_adel,         1,0,0,1,1});
    vq.push_back('{0,0,0,1,1,ExcCode_ri,2'b10,ExcCode_ov,ExcCode_adel, 1,0,0,1,1});
    vq.push_back('{0,1,1,1,0,0,2'b11,ExcCode_ov,ExcCode_adel,         0,0,0,0,0});
    vq.push_back('{0,0,0,1,0,0,2'b00,ExcCode_ov,ExcCode_adel,         1,0,0,0,0});
    for (int i = 0; i < 4; i++)
      vq.push_back('{0,1,0,1,0,0,2'b01,ExcCode_ov,ExcCode_adel,       1,0,0,0,0});
    vq.push_back('{0,0,0,1,0,0,2'b01,ExcCode_ov,ExcCode_adel,         1,1,ExcCode_adel,0,1});
    vq.push_back('{0,1,0,1,1,ExcCode_ov,2'b10,ExcCode_ov,ExcCode_ades, 1,1,ExcCode_adel,0,1});
    vq.push_back('{0,0,1,0,0,0,2'b00,0,0,                             0,0,0,0,0});
    // NSRC boundary: only the highest index requests
    vq.push_back('{0,0,0,1,0,0,2'b10,ExcCode_ades,ExcCode_adel,       1,1,ExcCode_ades,0,1});

    for (int v = 0; v < vq.size(); v++) begin
      drive(vq[v].rst, vq[v].stall, vq[v].flush, vq[v].ivi, vq[v].evi,
            vq[v].cin, vq[v].req, vq[v].c1, vq[v].c0);
      step();
      check($sformatf("vec%0d_ivo", v),  32'(bus.InstrValidOut), 32'(vq[v].e_ivo));
      check($sformatf("vec%0d_evo", v),  32'(bus.ExcValidOut),   32'(vq[v].e_evo));
      check($sformatf("vec%0d_code", v), 32'(bus.ExcCodeOut),    32'(vq[v].e_code));
      check($sformatf("vec%0d_kill", v), 32'(bus.KillOut),       32'(vq[v].e_kill));
      check($sformatf("vec%0d_pend", v), 32'(bus.Pend),          32'(vq[v].e_pend));
`ifdef EXC_STAGE_CNT_EN
      if (v == 1) check("vec1_cnt", 32'(bus.ExcCnt), 32'd0);
`endif
    end

    // Randomized run against the model
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    model_edge();
    step();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
            ($urandom_range(3) != 0), ($urandom_range(3) == 0), 5'($urandom),
            2'($urandom), 5'($urandom), 5'($urandom));
      model_edge();
      step();
      check($sformatf("rnd%0d_ivo", n),  32'(bus.InstrValidOut), 32'(m_ivo));
      check($sformatf("rnd%0d_evo", n),  32'(bus.ExcValidOut),   32'(m_evo));
      check($sformatf("rnd%0d_code", n), 32'(bus.ExcCodeOut),    32'(m_code));
      check($sformatf("rnd%0d_kill", n), 32'(bus.KillOut),       32'(m_kill));
      check($sformatf("rnd%0d_pend", n), 32'(bus.Pend),          32'(m_pend));
`ifdef EXC_STAGE_CNT_EN
      check($sformatf("rnd%0d_cnt", n),  32'(bus.ExcCnt),        32'(m_cnt));
`endif
    end

`ifdef EXC_STAGE_CNT_EN
    // Saturation: 65537 separate entries each closed by a flush
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int k = 0; k < 65537; k++) begin
      drive(0, 0, 0, 1, 1, ExcCode_ov, 0, 0, 0);
      step();
      if (k == 0) check("cnt_first", 32'(bus.ExcCnt), 32'd1);
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
      step();
    end
    check("cnt_sat", 32'(bus.ExcCnt), 32'hFFFF);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("cnt_reset", 32'(bus.ExcCnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
